// File: rtl/serial_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from a per-bit divisor,
// single-entry output register with valid/ready handshake and error pulses.
module serial_rx #(
  parameter int unsigned DIVISOR = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = 13;
  localparam int unsigned HALF  = DIVISOR / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_MARK
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             w_load;
  logic             w_ferr;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;

  // Line synchronizer; idles at MARK so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, bit-timing counter and shift datapath
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (!r_rx_s) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          if (!r_rx_s) begin
            w_state_next = S_DATA;
            w_bit_next   = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {r_rx_s, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next = '0;
          if (r_rx_s) begin
            w_load       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_state_next = S_WAIT_MARK;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_MARK: begin
        w_cnt_next = '0;
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_bit       <= w_bit_next;
      r_shift     <= w_shift_next;
      r_busy      <= (w_state_next != S_IDLE);
      r_frame_err <= w_ferr;
      r_overrun   <= w_load && r_valid && !ready;
      if (w_load) begin
        r_data  <= w_shift_next;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
